// File: rtl/widen_seq.sv
// Widening sequencer: latches one packed SEW=8/16 word and
// emits it as 1, 2 or 4 sign/zero-extended output beats.
module bit_ext #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  i_d,
  input  logic             i_sgn,
  output logic [OUT_W-1:0] o_d
);
  assign o_d = {{(OUT_W-IN_W){i_sgn & i_d[IN_W-1]}}, i_d};
endmodule

module widen_seq #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic [1:0]        in_mode,
  input  logic              in_signed,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
);

  if (WORD_W != 32) begin : g_bad_width
    $error("widen_seq: only WORD_W=32 is supported");
  end

  typedef enum logic {
    S_IDLE,
    S_EMIT
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_word;
  logic [1:0]  r_mode;
  logic        r_sign;
  logic [1:0]  r_beat;
  logic [1:0]  w_beat_nxt;
  logic        w_load;
  logic [1:0]  w_last_beat;
  logic        w_is_last;
  logic        w_out_xfer;
  logic        w_in_xfer;

  always_comb begin
    w_last_beat = 2'd0;
    unique case (r_mode)
      2'b00:   w_last_beat = 2'd1;
      2'b01:   w_last_beat = 2'd3;
      2'b10:   w_last_beat = 2'd1;
      default: w_last_beat = 2'd0;
    endcase
  end

  assign w_is_last  = (r_state == S_EMIT) && (r_beat == w_last_beat);
  assign w_out_xfer = out_valid && out_ready;
  assign w_in_xfer  = in_valid && in_ready;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= S_IDLE;
      r_beat  <= 2'd0;
      r_word  <= 32'd0;
      r_mode  <= 2'b00;
      r_sign  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
      if (w_load) begin
        r_word <= in_data[31:0];
        r_mode <= in_mode;
        r_sign <= in_signed;
      end
    end
  end

  // abort wins over both input and output transfers
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_load      = 1'b0;
    if (abort) begin
      w_state_nxt = S_IDLE;
      w_beat_nxt  = 2'd0;
    end else if (w_in_xfer) begin
      w_state_nxt = S_EMIT;
      w_beat_nxt  = 2'd0;
      w_load      = 1'b1;
    end else if (w_out_xfer && w_is_last) begin
      w_state_nxt = S_IDLE;
      w_beat_nxt  = 2'd0;
    end else if (w_out_xfer) begin
      w_beat_nxt  = r_beat + 2'd1;
    end
  end

  always_comb begin
    out_valid = (r_state == S_EMIT);
    busy      = (r_state == S_EMIT);
    out_last  = w_is_last;
    in_ready  = !abort &&
                ((r_state == S_IDLE) ||
                 (w_out_xfer && w_is_last));
  end

  logic [15:0] w_half;
  logic [7:0]  w_byte;
  logic [15:0] w_e16_lo;
  logic [15:0] w_e16_hi;
  logic [31:0] w_e32_b;
  logic [31:0] w_e32_h;

  assign w_half = r_beat[0] ? r_word[31:16] : r_word[15:0];

  always_comb begin
    w_byte = r_word[7:0];
    unique case (r_beat)
      2'd0:    w_byte = r_word[7:0];
      2'd1:    w_byte = r_word[15:8];
      2'd2:    w_byte = r_word[23:16];
      default: w_byte = r_word[31:24];
    endcase
  end

  bit_ext #(.IN_W(8), .OUT_W(16)) u_e16_lo (
    .i_d(w_half[7:0]), .i_sgn(r_sign), .o_d(w_e16_lo)
  );
  bit_ext #(.IN_W(8), .OUT_W(16)) u_e16_hi (
    .i_d(w_half[15:8]), .i_sgn(r_sign), .o_d(w_e16_hi)
  );
  bit_ext #(.IN_W(8), .OUT_W(32)) u_e32_b (
    .i_d(w_byte), .i_sgn(r_sign), .o_d(w_e32_b)
  );
  bit_ext #(.IN_W(16), .OUT_W(32)) u_e32_h (
    .i_d(w_half), .i_sgn(r_sign), .o_d(w_e32_h)
  );

  always_comb begin
    out_data = r_word;
    unique case (r_mode)
      2'b00:   out_data = {w_e16_hi, w_e16_lo};
      2'b01:   out_data = w_e32_b;
      2'b10:   out_data = w_e32_h;
      default: out_data = r_word;
    endcase
  end

endmodule

// File: tb/tb_widen_seq.sv
// Directed bench for widen_seq: modes, backpressure,
// back-to-back words, abort and asynchronous reset.
module tb_widen_seq;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'd0;
  logic [1:0]  in_mode = 2'b00;
  logic        in_signed = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  widen_seq #(.WORD_W(32)) dut (
    .clk(clk), .n_reset(n_reset), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode),
    .in_signed(in_signed), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic run_word(input string tag,
                          input logic [31:0] d,
                          input logic [1:0] m,
                          input logic s,
                          input int n,
                          input logic [31:0] e0, e1, e2, e3);
    logic [31:0] e [4];
    e = '{e0, e1, e2, e3};
    @(negedge clk);
    in_data = d; in_mode = m; in_signed = s;
    in_valid = 1'b1; out_ready = 1'b1;
    #1 chk({tag, " rdy"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0; in_mode = ~m; in_signed = ~s;
    in_data = ~d;
    for (int k = 0; k < n; k++) begin
      #1;
      chk($sformatf("%s vld%0d", tag, k), 32'(out_valid), 32'd1);
      chk($sformatf("%s dat%0d", tag, k), out_data, e[k]);
      chk($sformatf("%s lst%0d", tag, k), 32'(out_last),
          32'(k == n - 1));
      @(negedge clk);
    end
    #1 chk({tag, " idle"}, 32'(out_valid), 32'd0);
  endtask

  localparam logic [31:0] SRC = 32'h80FF7F01;

  initial begin
    logic [31:0] bp_exp [4];
    logic [31:0] bb_exp [6];
    logic [15:0] bp_pat;
    int idx;

    #2;
    chk("rst rdy", 32'(in_ready), 32'd1);
    chk("rst vld", 32'(out_valid), 32'd0);
    chk("rst lst", 32'(out_last), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst dat", out_data, 32'd0);
    @(negedge clk);
    n_reset = 1'b1;

    run_word("s816", SRC, 2'b00, 1'b1, 2,
             32'h007F0001, 32'hFF80FFFF, 0, 0);
    run_word("u816", SRC, 2'b00, 1'b0, 2,
             32'h007F0001, 32'h008000FF, 0, 0);
    run_word("s832", SRC, 2'b01, 1'b1, 4,
             32'h00000001, 32'h0000007F,
             32'hFFFFFFFF, 32'hFFFFFF80);
    run_word("s1632", SRC, 2'b10, 1'b1, 2,
             32'h00007F01, 32'hFFFF80FF, 0, 0);
    run_word("u1632", SRC, 2'b10, 1'b0, 2,
             32'h00007F01, 32'h000080FF, 0, 0);
    run_word("pass", SRC, 2'b11, 1'b1, 1,
             SRC, 0, 0, 0);

    // backpressure: stalled beat must hold its value
    bp_exp = '{32'h00000001, 32'h0000007F,
               32'hFFFFFFFF, 32'hFFFFFF80};
    bp_pat = 16'b1011_0010_1100_1010;
    @(negedge clk);
    in_data = SRC; in_mode = 2'b01; in_signed = 1'b1;
    in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    idx = 0;
    for (int c = 0; c < 40 && idx < 4; c++) begin
      out_ready = bp_pat[c % 16];
      #1;
      chk($sformatf("bp vld c%0d", c), 32'(out_valid), 32'd1);
      chk($sformatf("bp dat c%0d", c), out_data, bp_exp[idx]);
      chk($sformatf("bp lst c%0d", c), 32'(out_last),
          32'(idx == 3));
      if (out_ready) idx++;
      @(negedge clk);
    end
    chk("bp count", 32'(idx), 32'd4);
    #1 chk("bp idle", 32'(out_valid), 32'd0);

    // back-to-back: mode 01 then mode 00, no bubble
    bb_exp = '{32'h00000001, 32'h0000007F,
               32'hFFFFFFFF, 32'hFFFFFF80,
               32'h00F0000F, 32'h00800001};
    @(negedge clk);
    in_data = SRC; in_mode = 2'b01; in_signed = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_data = 32'h8001F00F; in_mode = 2'b00; in_signed = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c == 4) in_valid = 1'b0;
      #1;
      chk($sformatf("bb vld%0d", c), 32'(out_valid), 32'd1);
      chk($sformatf("bb dat%0d", c), out_data, bb_exp[c]);
      chk($sformatf("bb lst%0d", c), 32'(out_last),
          32'(c == 3 || c == 5));
      chk($sformatf("bb rdy%0d", c), 32'(in_ready),
          32'(c == 3 || c == 5));
      @(negedge clk);
    end
    #1 chk("bb idle", 32'(out_valid), 32'd0);

    // abort on beat 1 with a competing word offered
    @(negedge clk);
    in_data = SRC; in_mode = 2'b01; in_signed = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("ab b0", out_data, 32'h00000001);
    @(negedge clk);
    in_data = 32'h12345678; in_mode = 2'b11;
    in_valid = 1'b1; abort = 1'b1;
    #1;
    chk("ab b1", out_data, 32'h0000007F);
    chk("ab rdy", 32'(in_ready), 32'd0);
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b0;
    #1;
    chk("ab vld", 32'(out_valid), 32'd0);
    chk("ab busy", 32'(busy), 32'd0);
    run_word("ab nxt", SRC, 2'b10, 1'b1, 2,
             32'h00007F01, 32'hFFFF80FF, 0, 0);

    // asynchronous reset mid-word
    @(negedge clk);
    in_data = SRC; in_mode = 2'b01; in_signed = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("mr b0", out_data, 32'h00000001);
    #2 n_reset = 1'b0;
    #1;
    chk("mr vld", 32'(out_valid), 32'd0);
    chk("mr busy", 32'(busy), 32'd0);
    chk("mr rdy", 32'(in_ready), 32'd1);
    chk("mr dat", out_data, 32'd0);
    @(negedge clk);
    n_reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1 chk("mr stale", 32'(out_valid), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
